// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and defaults for the count sequencer.
// State encoding is exported on the debug state port.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LIMIT = 9;

endpackage

// File: rtl/count_sequencer_core.sv
// count_core: reusable up-counter with clear, enable and limit compare.
// at_limit is combinational so the owner can compare before incrementing.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven FSM sequencing count_core runs.
// Sole owner of the counter's clear and enable.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEFAULT_LIMIT = DEF_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_auto,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    state_t           st;
    logic [WIDTH-1:0] limit_reg;
    logic             auto_reg;
    logic             clr;
    logic             en;
    logic             at_limit;

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (en),
        .limit    (limit_reg),
        .count    (count),
        .at_limit (at_limit)
    );

    // Compare precedes increment, so a full-scale limit never overflows.
    always_comb begin
        clr = 1'b0;
        en  = 1'b0;
        unique case (st)
            IDLE: clr = cmd_valid;
            RUN: begin
                if (abort) begin
                    clr = 1'b1;
                end else if (!pause) begin
                    if (at_limit) begin
                        clr = auto_reg;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            PAUSED: clr = abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            limit_reg <= WIDTH'(DEFAULT_LIMIT);
            auto_reg  <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (cmd_valid) begin
                        limit_reg <= cmd_limit;
                        auto_reg  <= cmd_auto;
                        st        <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (pause) begin
                        st <= PAUSED;
                    end else if (at_limit) begin
                        if (auto_reg) begin
                            wrap <= 1'b1;
                        end else begin
                            done <= 1'b1;
                            st   <= IDLE;
                        end
                    end
                end
                PAUSED: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (!pause) begin
                        st <= RUN;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (st == IDLE);
    assign busy      = (st != IDLE);
    assign state     = st;

endmodule
